ppheavy_multi_timer: RTL and testbench

- Parametrised successor to the single-channel pre-polarisation (ppheavy) on-timer in the 2D NMR sequencer.
- While the sequencer holds state_start high, it counts clk_10k cycles and emits registered one-cycle strobes at up to NUM_PULSE programmable count positions.
- Supports one-shot mode (count stops at a programmable end) and repeat mode (count wraps).
- Drives downstream pulse and acquisition triggers.

---
 rtl/ppheavy_pkg.sv | 12 +
 rtl/ppheavy_multi_timer_if.sv | 30 +++
 rtl/ppheavy_match_slot.sv | 16 +
 rtl/ppheavy_multi_timer.sv | 141 ++++++++++++++
 tb/tb_ppheavy_multi_timer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/ppheavy_pkg.sv
// Shared defaults and helpers for the multi-slot pre-polarisation timer.
package ppheavy_pkg;

    localparam int unsigned CNT_W_DEF     = 8;
    localparam int unsigned NUM_PULSE_DEF = 4;

    // Bit offset of slot idx inside a flattened position vector of w-bit fields.
    function automatic int unsigned pos_lsb(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/ppheavy_multi_timer_if.sv
// Sequencer-facing bundle: run gate and configuration in, strobes and count out.
interface ppheavy_multi_timer_if #(
    parameter int unsigned CNT_W     = ppheavy_pkg::CNT_W_DEF,
    parameter int unsigned NUM_PULSE = ppheavy_pkg::NUM_PULSE_DEF,
    parameter int unsigned IDX_W     = 2
);
    logic                         state_start;
    logic                         mode_repeat;
    logic [CNT_W-1:0]             period;
    logic [NUM_PULSE*CNT_W-1:0]   pulse_pos;
    logic [NUM_PULSE-1:0]         pulse_en;
    logic                         start;
    logic [IDX_W-1:0]             start_idx;
    logic [NUM_PULSE-1:0]         pulse_hit;
    logic [CNT_W-1:0]             count;
    logic                         done;
    logic                         wrap;

    // Sequencer side.
    modport master (
        output state_start, mode_repeat, period, pulse_pos, pulse_en,
        input  start, start_idx, pulse_hit, count, done, wrap
    );

    // Timer side.
    modport slave (
        input  state_start, mode_repeat, period, pulse_pos, pulse_en,
        output start, start_idx, pulse_hit, count, done, wrap
    );
endinterface

// File: rtl/ppheavy_match_slot.sv
// One pulse-position slot: fires while running when the count freshly equals its position.
module ppheavy_match_slot #(
    parameter int unsigned CNT_W = ppheavy_pkg::CNT_W_DEF
) (
    input  logic             active_i,
    input  logic             fresh_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] pos_i,
    input  logic [CNT_W-1:0] count_i,
    output logic             hit_c_o
);

    // fresh_i suppresses repeat hits while a one-shot run holds at its end count.
    assign hit_c_o = active_i & fresh_i & en_i & (count_i == pos_i);

endmodule

// File: rtl/ppheavy_multi_timer.sv
// Multi-slot pre-polarisation on-timer: gated counter, shadowed config, registered strobes.
module ppheavy_multi_timer
    import ppheavy_pkg::*;
#(
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned NUM_PULSE = NUM_PULSE_DEF,
    parameter int unsigned IDX_W     = 2
) (
    input  logic                  clk_10k,
    input  logic                  rst_n,
    ppheavy_multi_timer_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                       mode_q;
    logic [CNT_W-1:0]           period_q;
    logic [NUM_PULSE*CNT_W-1:0] pos_q;
    logic [NUM_PULSE-1:0]       en_q;

    logic                       active_q, active_d;
    logic                       adv_q, adv_d;
    logic                       done_q, done_d;
    logic                       wrap_q, wrap_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       latch_c;

    logic                       start_q;
    logic [IDX_W-1:0]           start_idx_q, idx_c;
    logic [NUM_PULSE-1:0]       pulse_hit_q, hit_c;
    logic [CNT_W-1:0]           end_c;

    // A zero period means run to the top of the counter range.
    assign end_c = (period_q == '0) ? CNT_MAX : period_q;

    // Next-state for the run counter; adv marks a cycle whose count is newly reached.
    always_comb begin
        count_d  = count_q;
        active_d = active_q;
        adv_d    = adv_q;
        done_d   = done_q;
        wrap_d   = 1'b0;
        latch_c  = 1'b0;
        if (!bus.state_start) begin
            count_d  = '0;
            active_d = 1'b0;
            adv_d    = 1'b0;
            done_d   = 1'b0;
        end else if (!active_q) begin
            latch_c  = 1'b1;
            count_d  = CNT_W'(1);
            active_d = 1'b1;
            adv_d    = 1'b1;
        end else if (count_q != end_c) begin
            count_d  = count_q + CNT_W'(1);
            adv_d    = 1'b1;
        end else if (mode_q) begin
            count_d  = CNT_W'(1);
            adv_d    = 1'b1;
            wrap_d   = 1'b1;
        end else begin
            adv_d    = 1'b0;
            done_d   = 1'b1;
        end
    end

    // Configuration shadow, captured once at the start of each run.
    always_ff @(posedge clk_10k or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= 1'b0;
            period_q <= '0;
            pos_q    <= '0;
            en_q     <= '0;
        end else if (latch_c) begin
            mode_q   <= bus.mode_repeat;
            period_q <= bus.period;
            pos_q    <= bus.pulse_pos;
            en_q     <= bus.pulse_en;
        end
    end

    // Counter and run-state registers.
    always_ff @(posedge clk_10k or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            active_q <= 1'b0;
            adv_q    <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            active_q <= active_d;
            adv_q    <= adv_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
        end
    end

    // Per-slot comparators.
    for (genvar g = 0; g < int'(NUM_PULSE); g++) begin : g_slot
        ppheavy_match_slot #(
            .CNT_W (CNT_W)
        ) u_slot (
            .active_i (active_q),
            .fresh_i  (adv_q),
            .en_i     (en_q[g]),
            .pos_i    (pos_q[pos_lsb(g, CNT_W) +: CNT_W]),
            .count_i  (count_q),
            .hit_c_o  (hit_c[g])
        );
    end

    // Lowest-index slot wins the start_idx report.
    always_comb begin
        idx_c = '0;
        for (int i = int'(NUM_PULSE) - 1; i >= 0; i--) begin
            if (hit_c[i]) idx_c = IDX_W'(i);
        end
    end

    // Registered strobe outputs.
    always_ff @(posedge clk_10k or negedge rst_n) begin
        if (!rst_n) begin
            start_q     <= 1'b0;
            start_idx_q <= '0;
            pulse_hit_q <= '0;
        end else begin
            start_q     <= |hit_c;
            start_idx_q <= idx_c;
            pulse_hit_q <= hit_c;
        end
    end

    assign bus.start     = start_q;
    assign bus.start_idx = start_idx_q;
    assign bus.pulse_hit = pulse_hit_q;
    assign bus.count     = count_q;
    assign bus.done      = done_q;
    assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_ppheavy_multi_timer.sv
// Bench for ppheavy_multi_timer: directed scenarios plus randomized runs against an edge-count model.
module tb_ppheavy_multi_timer;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned NP    = 4;
    localparam int unsigned IDX_W = 2;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic clk_10k = 1'b0;
    logic rst_n;
    always #50 clk_10k = ~clk_10k;

    ppheavy_multi_timer_if #(.CNT_W(CNT_W), .NUM_PULSE(NP), .IDX_W(IDX_W)) bus ();

    ppheavy_multi_timer #(.CNT_W(CNT_W), .NUM_PULSE(NP), .IDX_W(IDX_W)) dut (
        .clk_10k (clk_10k),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    string phase = "init";

    // Reference model: the whole run is described by k, the number of consecutive high edges.
    int               k;
    logic             sh_mode;
    int               sh_p;
    int               sh_pos [NP];
    logic [NP-1:0]    sh_en;
    logic [CNT_W-1:0] e_count;
    logic             e_start, e_done, e_wrap;
    logic [IDX_W-1:0] e_idx;
    logic [NP-1:0]    e_hit;

    int               n_start;
    logic [NP-1:0]    last_hit;
    logic [IDX_W-1:0] last_idx;

    function automatic int cnt_of(input int kk);
        if (kk == 0) return 0;
        if (sh_mode) return ((kk - 1) % sh_p) + 1;
        return (kk < sh_p) ? kk : sh_p;
    endfunction

    task automatic model_reset();
        k = 0; sh_mode = 1'b0; sh_p = CMAX; sh_en = '0;
        for (int i = 0; i < int'(NP); i++) sh_pos[i] = 0;
        e_count = '0; e_start = 1'b0; e_done = 1'b0; e_wrap = 1'b0; e_idx = '0; e_hit = '0;
    endtask

    task automatic model_edge();
        int kb;
        int c;
        logic g;
        logic [NP-1:0] h;
        kb = k;
        g  = bus.state_start;
        h  = '0;
        if (kb >= 1) begin
            c = cnt_of(kb);
            if (sh_mode || kb <= sh_p)
                for (int i = 0; i < int'(NP); i++)
                    if (sh_en[i] && sh_pos[i] == c) h[i] = 1'b1;
        end
        e_hit   = h;
        e_start = |h;
        e_idx   = '0;
        for (int i = int'(NP) - 1; i >= 0; i--) if (h[i]) e_idx = IDX_W'(i);
        e_wrap = g && kb >= 1 && sh_mode && cnt_of(kb) == sh_p;
        e_done = g && kb >= 1 && !sh_mode && kb >= sh_p;
        if (g) begin
            if (kb == 0) begin
                sh_mode = bus.mode_repeat;
                sh_p    = (bus.period == '0) ? CMAX : int'(bus.period);
                sh_en   = bus.pulse_en;
                for (int i = 0; i < int'(NP); i++)
                    sh_pos[i] = int'(bus.pulse_pos[i*CNT_W +: CNT_W]);
            end
            k = kb + 1;
        end else begin
            k = 0;
        end
        e_count = CNT_W'(cnt_of(k));
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count",     32'(bus.count),     32'(e_count));
        chk("start",     32'(bus.start),     32'(e_start));
        chk("start_idx", 32'(bus.start_idx), 32'(e_idx));
        chk("pulse_hit", 32'(bus.pulse_hit), 32'(e_hit));
        chk("done",      32'(bus.done),      32'(e_done));
        chk("wrap",      32'(bus.wrap),      32'(e_wrap));
    endtask

    task automatic tick();
        @(posedge clk_10k);
        model_edge();
        #1;
        check_all();
        if (bus.start === 1'b1) begin
            n_start++;
            last_hit = bus.pulse_hit;
            last_idx = bus.start_idx;
        end
    endtask

    task automatic set_cfg(input logic m, input int per, input int p0, input int p1,
                           input int p2, input int p3, input logic [NP-1:0] en);
        bus.mode_repeat = m;
        bus.period      = CNT_W'(per);
        bus.pulse_pos   = {CNT_W'(p3), CNT_W'(p2), CNT_W'(p1), CNT_W'(p0)};
        bus.pulse_en    = en;
    endtask

    task automatic scramble();
        bus.mode_repeat = 1'($urandom);
        bus.period      = CNT_W'($urandom);
        bus.pulse_pos   = (NP*CNT_W)'({$urandom, $urandom});
        bus.pulse_en    = NP'($urandom);
    endtask

    task automatic run(input int n);
        bus.state_start = 1'b1;
        repeat (n) tick();
    endtask

    task automatic idle(input int n);
        bus.state_start = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        bus.state_start = 1'b0;
        set_cfg(1'b0, 0, 0, 0, 0, 0, '0);
        model_reset();
        n_start = 0; last_hit = '0; last_idx = '0;
        rst_n = 1'b1;
        #5 rst_n = 1'b0;
        repeat (2) @(posedge clk_10k);
        #1;
        phase = "reset";
        check_all();
        #20 rst_n = 1'b1;
        idle(2);

        phase = "legacy";
        set_cfg(1'b0, 63, 20, 35, 0, 0, 4'b0011);
        n_start = 0;
        run(70);
        chk("n_start", 32'(n_start), 32'd2);
        chk("end_count", 32'(bus.count), 32'd63);
        chk("end_done", 32'(bus.done), 32'd1);
        idle(2);

        phase = "repeat";
        set_cfg(1'b1, 10, 3, 0, 0, 0, 4'b0001);
        n_start = 0;
        run(35);
        chk("n_start", 32'(n_start), 32'd4);
        idle(1);

        phase = "hold";
        set_cfg(1'b0, 5, 5, 0, 0, 0, 4'b0001);
        n_start = 0;
        run(12);
        chk("n_start", 32'(n_start), 32'd1);
        chk("hold_count", 32'(bus.count), 32'd5);
        idle(1);

        phase = "dup";
        set_cfg(1'b0, 20, 7, 7, 7, 25, 4'b1110);
        n_start = 0;
        run(30);
        chk("n_start", 32'(n_start), 32'd1);
        chk("dup_hit", 32'(last_hit), 32'h6);
        chk("dup_idx", 32'(last_idx), 32'd1);
        idle(1);

        phase = "midrun";
        set_cfg(1'b0, 100, 5, 15, 0, 0, 4'b0011);
        n_start = 0;
        run(6);
        set_cfg(1'b1, 9, 8, 9, 10, 11, 4'b1111);
        run(6);
        chk("drop_count", 32'(bus.count), 32'd12);
        idle(5);
        chk("n_start", 32'(n_start), 32'd1);
        run(12);
        idle(1);

        phase = "areset";
        set_cfg(1'b0, 0, 31, 0, 0, 0, 4'b0001);
        run(30);
        #20 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        bus.state_start = 1'b0;
        #10 rst_n = 1'b1;
        idle(3);
        run(4);
        idle(1);

        phase = "random";
        for (int r = 0; r < 24; r++) begin
            scramble();
            if (($urandom % 4) != 0) bus.period = CNT_W'($urandom_range(1, 40));
            for (int i = 0; i < int'(NP); i++)
                bus.pulse_pos[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 45));
            bus.state_start = 1'b1;
            for (int c = 0; c < int'($urandom_range(1, 80)); c++) begin
                tick();
                if (($urandom % 3) == 0) scramble();
            end
            idle($urandom_range(1, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
